uart_seq: RTL and testbench
===========================

UART_SEQ -- requirements
Module: uart_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, uart register data width.
REQ-002 SHALL have parameter CPB_INIT, default 217, cycles-per-bit value loaded into the uart after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port tx_data, input, 8, byte offered by the producer.
REQ-006 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-007 SHALL have port tx_ready, output, 1, the TX FIFO accepts; the push happens when tx_valid & tx_ready.
REQ-008 SHALL have port rx_data, output, 8, head of the RX FIFO.
REQ-009 SHALL have port rx_valid, output, 1, the RX FIFO is not empty.
REQ-010 SHALL have port rx_ready, input, 1, the consumer pops when rx_valid & rx_ready.
REQ-011 SHALL have port rx_overrun, output, 1, sticky flag: a received byte was dropped.
REQ-012 SHALL have port u_cs, output, 1, uart chip select.
REQ-013 SHALL have port u_wen, output, 1, uart write enable.
REQ-014 SHALL have port u_addr, output, 4, uart register address.
REQ-015 SHALL have port u_din, output, WIDTH, write data to the uart.
REQ-016 SHALL have port u_dout, input, WIDTH, combinational read data from the uart.

Function
REQ-017 SHALL contain a TX FIFO and an RX FIFO, each 4 entries of 8 bits, with occupancy counters 0..4.
REQ-018 tx_ready SHALL be 1 iff TX occupancy < 4; rx_valid SHALL be 1 iff RX occupancy > 0; rx_data SHALL show the RX head combinationally.
REQ-019 SHALL run an FSM with states RST, CPB, CTRL, TSTAT, TXW, RSTAT, RXR, GAP; exactly one uart access per state cycle, except in RST and GAP.
REQ-020 RST: u_cs=0; next state CPB.
REQ-021 CPB: write, u_addr=4, u_din=CPB_INIT; next state CTRL.
REQ-022 CTRL: write, u_addr=1, u_din=3 (RX_EN|TX_EN); next state TSTAT.
REQ-023 TSTAT: read, u_addr=3; if u_dout[0]=1 and TX occupancy>0, next state TXW; otherwise next state RSTAT.
REQ-024 TXW: write, u_addr=0, u_din={0,TX head}; pop the TX FIFO in the same cycle; next state RSTAT.
REQ-025 RSTAT: read, u_addr=2; if u_dout[0]=1 (RXNE), next state RXR; otherwise next state TSTAT.
REQ-026 RXR: read, u_addr=0; u_dout[7:0] SHALL be pushed into the RX FIFO; next state TSTAT.
REQ-027 In RXR with RX occupancy=4 (value before any same-cycle pop), the byte SHALL be dropped and rx_overrun set to 1; a same-cycle consumer pop still completes.
REQ-028 In any cycle where u_cs=0, u_wen SHALL be 0. In every read state, u_wen=0 and u_din=0.
REQ-029 A simultaneous producer push and TXW pop SHALL leave TX occupancy unchanged. A simultaneous RXR push and consumer pop SHALL behave the same for the RX FIFO.
REQ-030 Two successive TSTAT polls SHALL be at least 2 cycles apart, so the uart busy flag settles after a DR write.
REQ-031 Bytes SHALL leave in push order with no duplication or loss on the TX side.

Reset
REQ-032 On resetn=0, the FSM SHALL go to RST immediately (asynchronously).
REQ-033 On resetn=0, both FIFOs SHALL be emptied: tx_ready=1, rx_valid=0.
REQ-034 On resetn=0, rx_overrun=0, u_cs=0, u_wen=0, u_addr=0, u_din=0.
REQ-035 A reset during any state, including TXW or RXR, SHALL abort the access; the uart is reprogrammed via CPB and CTRL after release.
REQ-036 rx_overrun SHALL clear only on reset.

Configuration
REQ-037 Macro UART_SEQ_RX_EN defined: behaviour is as above.
REQ-038 Macro UART_SEQ_RX_EN undefined:
- no RX FIFO and no RSTAT/RXR states;
- CTRL writes 2 (TX_EN only);
- TSTAT without a send goes to GAP; TXW goes to GAP; GAP goes to TSTAT;
- rx_valid=0, rx_data=0, rx_overrun=0; rx_ready is ignored.

Verification
REQ-039 Release reset -> cycle 1 RST with u_cs=0; then CPB write addr 4 data 217; then CTRL write addr 1 data 3.
REQ-040 Push 0x41, 0x42 with u_dout[0]=1 during TSTAT -> DR writes of 0x41 then 0x42 in order; tx_ready stays 1.
REQ-041 Push 5 bytes while TSTAT returns 0 -> tx_ready=0 after the 4th push; the 5th is held until a TXW pop frees a slot.
REQ-042 RSTAT returns 1 and DR returns 0x5A -> rx_valid=1, rx_data=0x5A; pop with rx_ready=1 -> rx_valid=0.
REQ-043 Five received bytes with rx_ready=0 -> the first 4 are kept; the 5th is dropped and rx_overrun=1 until reset.
REQ-044 Assert resetn=0 mid-TXW -> outputs return to reset values in the same cycle; after release, the CPB/CTRL sequence repeats.

Source files
------------

// File: rtl/uart_seq.sv
// rtl/uart_seq.sv - byte-stream sequencer driving a register-mapped uart (optional RX path: UART_SEQ_RX_EN)
module uart_seq #(
  parameter int WIDTH    = 32,
  parameter int CPB_INIT = 217
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             u_cs,
  output logic             u_wen,
  output logic [3:0]       u_addr,
  output logic [WIDTH-1:0] u_din,
  input  logic [WIDTH-1:0] u_dout
);

  localparam logic [3:0] ADDR_DR    = 4'd0;
  localparam logic [3:0] ADDR_CTRL  = 4'd1;
  localparam logic [3:0] ADDR_RSTAT = 4'd2;
  localparam logic [3:0] ADDR_TSTAT = 4'd3;
  localparam logic [3:0] ADDR_CPB   = 4'd4;
`ifdef UART_SEQ_RX_EN
  localparam logic [WIDTH-1:0] CTRL_VAL = WIDTH'(3);
`else
  localparam logic [WIDTH-1:0] CTRL_VAL = WIDTH'(2);
`endif

  typedef enum logic [2:0] {
    ST_RST, ST_CPB, ST_CTRL, ST_TSTAT, ST_TXW, ST_GAP
`ifdef UART_SEQ_RX_EN
    , ST_RSTAT, ST_RXR
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             cs_q, cs_d, wen_q, wen_d;
  logic [3:0]       addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;

  // TX FIFO storage
  logic [7:0] tx_mem_q [4];
  logic [7:0] tx_mem_d [4];
  logic [1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic       tx_push, tx_pop;

  logic unused_ok;
  assign unused_ok = ^{rx_ready, u_dout};

  assign tx_ready = (tx_cnt_q < 3'd4);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = (state_q == ST_TXW);

  // TX FIFO next-state: a push and a pop in the same cycle cancel in the count
  always_comb begin
    tx_mem_d = tx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    if (tx_push) begin
      tx_mem_d[tx_wr_q] = tx_data;
      tx_wr_d = tx_wr_q + 2'd1;
    end
    if (tx_pop) tx_rd_d = tx_rd_q + 2'd1;
    tx_cnt_d = tx_cnt_q + {2'b00, tx_push} - {2'b00, tx_pop};
  end

`ifdef UART_SEQ_RX_EN
  logic [7:0] rx_mem_q [4];
  logic [7:0] rx_mem_d [4];
  logic [1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [2:0] rx_cnt_q, rx_cnt_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_in, rx_push, rx_pop;

  assign rx_valid   = (rx_cnt_q != 3'd0);
  assign rx_data    = rx_mem_q[rx_rd_q];
  assign rx_overrun = rx_ovr_q;
  assign rx_in      = (state_q == ST_RXR);
  // fullness is judged before any same-cycle consumer pop
  assign rx_push    = rx_in & (rx_cnt_q != 3'd4);
  assign rx_pop     = rx_valid & rx_ready;

  // RX FIFO next-state with sticky overrun on a dropped byte
  always_comb begin
    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_ovr_d = rx_ovr_q | (rx_in & ~rx_push);
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = u_dout[7:0];
      rx_wr_d = rx_wr_q + 2'd1;
    end
    if (rx_pop) rx_rd_d = rx_rd_q + 2'd1;
    rx_cnt_d = rx_cnt_q + {2'b00, rx_push} - {2'b00, rx_pop};
  end

  // RX FIFO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) rx_mem_q[i] <= 8'h00;
      rx_wr_q  <= 2'd0;
      rx_rd_q  <= 2'd0;
      rx_cnt_q <= 3'd0;
      rx_ovr_q <= 1'b0;
    end else begin
      rx_mem_q <= rx_mem_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      rx_ovr_q <= rx_ovr_d;
    end
  end
`else
  assign rx_valid   = 1'b0;
  assign rx_data    = 8'h00;
  assign rx_overrun = 1'b0;
`endif

  // Sequencer next state, then the uart access belonging to that next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:   state_d = ST_CPB;
      ST_CPB:   state_d = ST_CTRL;
      ST_CTRL:  state_d = ST_TSTAT;
`ifdef UART_SEQ_RX_EN
      ST_TSTAT: state_d = (u_dout[0] && tx_cnt_q != 3'd0) ? ST_TXW : ST_RSTAT;
      ST_TXW:   state_d = ST_RSTAT;
      ST_RSTAT: state_d = u_dout[0] ? ST_RXR : ST_TSTAT;
      ST_RXR:   state_d = ST_TSTAT;
`else
      ST_TSTAT: state_d = (u_dout[0] && tx_cnt_q != 3'd0) ? ST_TXW : ST_GAP;
      ST_TXW:   state_d = ST_GAP;
`endif
      ST_GAP:   state_d = ST_TSTAT;
      default:  state_d = ST_RST;
    endcase

    cs_d   = 1'b0;
    wen_d  = 1'b0;
    addr_d = 4'd0;
    din_d  = '0;
    case (state_d)
      ST_CPB:   begin cs_d = 1'b1; wen_d = 1'b1; addr_d = ADDR_CPB;  din_d = WIDTH'(CPB_INIT); end
      ST_CTRL:  begin cs_d = 1'b1; wen_d = 1'b1; addr_d = ADDR_CTRL; din_d = CTRL_VAL; end
      ST_TSTAT: begin cs_d = 1'b1; addr_d = ADDR_TSTAT; end
      // head is stable across this edge: the pop only happens while in TXW
      ST_TXW:   begin cs_d = 1'b1; wen_d = 1'b1; addr_d = ADDR_DR;
                      din_d = {{(WIDTH-8){1'b0}}, tx_mem_q[tx_rd_q]}; end
`ifdef UART_SEQ_RX_EN
      ST_RSTAT: begin cs_d = 1'b1; addr_d = ADDR_RSTAT; end
      ST_RXR:   begin cs_d = 1'b1; addr_d = ADDR_DR; end
`endif
      default:  ;
    endcase
  end

  // Sequencer state, registered uart bus and TX FIFO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_RST;
      cs_q     <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= 4'd0;
      din_q    <= '0;
      for (int i = 0; i < 4; i++) tx_mem_q[i] <= 8'h00;
      tx_wr_q  <= 2'd0;
      tx_rd_q  <= 2'd0;
      tx_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      tx_mem_q <= tx_mem_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign u_cs   = cs_q;
  assign u_wen  = wen_q;
  assign u_addr = addr_q;
  assign u_din  = din_q;

endmodule

// File: tb/tb_uart_seq.sv
// tb/tb_uart_seq.sv - randomized and directed bench for uart_seq against a queue-based model
module tb_uart_seq;

  localparam int WIDTH = 32;
`ifdef UART_SEQ_RX_EN
  localparam logic [63:0] CTRL_EXP = 64'd3;
`else
  localparam logic [63:0] CTRL_EXP = 64'd2;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready = 1'b0;
  logic             rx_overrun;
  logic             u_cs, u_wen;
  logic [3:0]       u_addr;
  logic [WIDTH-1:0] u_din;
  logic [WIDTH-1:0] u_dout;

  logic       tstat_bit = 1'b0;
  logic       rstat_bit = 1'b0;
  logic [7:0] rx_byte   = 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_tstat = -100;
  int rxr_seen = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic ovr_exp = 1'b0;

  uart_seq #(.WIDTH(WIDTH), .CPB_INIT(217)) dut (
    .clk(clk), .resetn(resetn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
    .u_cs(u_cs), .u_wen(u_wen), .u_addr(u_addr), .u_din(u_din), .u_dout(u_dout)
  );

  always #5 clk = ~clk;

  // uart register file model: status bits and DR read data come from bench variables
  always_comb begin
    u_dout = '0;
    case (u_addr)
      4'd3: u_dout = {31'b0, tstat_bit};
      4'd2: u_dout = {31'b0, rstat_bit};
      4'd0: u_dout = {24'b0, rx_byte};
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bound expired or illegal event", tag);
  endtask

  // one clock: observe bus before the edge, advance the model, compare after the edge
  task automatic tick();
    bit         push, drw, rxr, pop, full;
    logic [7:0] pdata, rb;
    push  = tx_valid && (tx_q.size() < 4);
    pdata = tx_data;
    drw   = u_cs && u_wen && (u_addr == 4'd0);
    rxr   = u_cs && !u_wen && (u_addr == 4'd0);
    rb    = rx_byte;
    full  = (rx_q.size() == 4);
    pop   = rx_ready && (rx_q.size() > 0);
    if (!u_cs) chk("idle_wen", u_wen, 0);
    if (u_cs && !u_wen) chk("read_din", u_din, 0);
    if (u_cs && !u_wen && u_addr == 4'd3) begin
      chk("tstat_spacing", 64'((cyc - last_tstat) >= 2), 1);
      last_tstat = cyc;
    end
    if (drw) begin
      if (tx_q.size() == 0) fail_now("dr_write_empty");
      else chk("dr_data", u_din, {56'b0, tx_q[0]});
    end
`ifdef UART_SEQ_RX_EN
    if (pop) chk("rx_data", rx_data, rx_q[0]);
`endif
    @(posedge clk);
    #1;
    cyc++;
    if (drw && tx_q.size() > 0) void'(tx_q.pop_front());
    if (push) tx_q.push_back(pdata);
    chk("tx_ready", tx_ready, 64'(tx_q.size() < 4));
`ifdef UART_SEQ_RX_EN
    if (pop) void'(rx_q.pop_front());
    if (rxr) begin
      rxr_seen++;
      if (full) ovr_exp = 1'b1;
      else rx_q.push_back(rb);
    end
    chk("rx_valid", rx_valid, 64'(rx_q.size() > 0));
    chk("rx_overrun", rx_overrun, ovr_exp);
`else
    if (rxr) fail_now("rx_read_disabled");
    chk("rx_valid_off", rx_valid, 0);
    chk("rx_overrun_off", rx_overrun, 0);
    chk("rx_data_off", rx_data, 0);
`endif
  endtask

  task automatic check_reset_vals();
    chk("rst_cs", u_cs, 0);
    chk("rst_wen", u_wen, 0);
    chk("rst_addr", u_addr, 0);
    chk("rst_din", u_din, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    ovr_exp = 1'b0;
    last_tstat = -100;
  endtask

  task automatic check_boot();
    chk("boot_rst_cs", u_cs, 0);
    tick();
    chk("cpb_cs", u_cs, 1);
    chk("cpb_wen", u_wen, 1);
    chk("cpb_addr", u_addr, 4);
    chk("cpb_din", u_din, 217);
    tick();
    chk("ctrl_wen", u_wen, 1);
    chk("ctrl_addr", u_addr, 1);
    chk("ctrl_din", u_din, CTRL_EXP);
    tick();
    chk("tstat_cs", u_cs, 1);
    chk("tstat_wen", u_wen, 0);
    chk("tstat_addr", u_addr, 3);
  endtask

  task automatic drain_tx();
    int budget;
    budget = 100;
    tx_valid  = 1'b0;
    tstat_bit = 1'b1;
    while (tx_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (tx_q.size() > 0) fail_now("tx_drain");
  endtask

  initial begin
    int budget;
    bit found;
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    @(posedge clk); @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
    check_boot();

    // two bytes go out in order while the uart reports ready
    tstat_bit = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h41; tick();
    chk("ready_after_41", tx_ready, 1);
    tx_data = 8'h42; tick();
    chk("ready_after_42", tx_ready, 1);
    drain_tx();

    // uart busy: fifo fills, fifth byte waits for a slot
    tstat_bit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'h10 + 8'(i); tick();
    end
    chk("full_after_4", tx_ready, 0);
    tx_data = 8'h14;
    for (int i = 0; i < 5; i++) tick();
    chk("fifth_held", tx_ready, 0);
    tstat_bit = 1'b1;
    budget = 30;
    found = 1'b0;
    while (!found && budget > 0) begin
      found = (tx_q.size() < 4);
      tick();
      budget--;
    end
    if (!found) fail_now("fifth_accept");
    drain_tx();

`ifdef UART_SEQ_RX_EN
    // single received byte, then consumer pop
    tstat_bit = 1'b0; rstat_bit = 1'b1; rx_byte = 8'h5A; rx_ready = 1'b0;
    budget = 20;
    while (rx_q.size() == 0 && budget > 0) begin tick(); budget--; end
    if (rx_q.size() == 0) fail_now("rx_first");
    rstat_bit = 1'b0;
    chk("rx_5a", rx_data, 8'h5A);
    rx_ready = 1'b1; tick(); tick();
    chk("rx_empty_after_pop", rx_valid, 0);
    rx_ready = 1'b0;

    // five arrivals with no consumer: last one is dropped
    rstat_bit = 1'b1;
    rxr_seen = 0;
    budget = 60;
    while (rxr_seen < 5 && budget > 0) begin
      rx_byte = 8'($urandom);
      tick();
      budget--;
    end
    if (rxr_seen < 5) fail_now("rx_five");
    rstat_bit = 1'b0;
    chk("overrun_set", rx_overrun, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("overrun_sticky", rx_overrun, 1);
    rx_ready = 1'b0;
`endif

    // randomized traffic on both sides
    for (int i = 0; i < 400; i++) begin
      tx_valid  = 1'($urandom);
      tx_data   = 8'($urandom);
      tstat_bit = ($urandom_range(0, 3) != 0);
      rstat_bit = 1'($urandom);
      rx_ready  = 1'($urandom);
      rx_byte   = 8'($urandom);
      tick();
    end
    rstat_bit = 1'b0;
    drain_tx();

    // reset in the middle of a DR write
    tx_valid = 1'b1; tx_data = 8'h77; tick();
    tx_valid = 1'b0;
    budget = 20;
    found = u_cs && u_wen && (u_addr == 4'd0);
    while (!found && budget > 0) begin
      tick();
      budget--;
      found = u_cs && u_wen && (u_addr == 4'd0);
    end
    if (!found) fail_now("txw_reach");
    #2 resetn = 1'b0;
    #1 check_reset_vals();
    model_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    check_boot();
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
